// File: rtl/module_gray_input.sv
// module_gray_input: synchronizes and debounces the DIP-switch Gray word, strobes updates,
// and flags accepted changes that flip more than one bit.
module module_gray_input #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] gray_out,
  output logic             upd,
  output logic             busy,
  output logic             gray_err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {STABLE, SETTLE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] sync_m, sync_q, cand, cand_d, gray_d;
  logic [CW-1:0] cnt, cnt_d;
  logic upd_d, err_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m   <= '0;
      sync_q   <= '0;
      state    <= STABLE;
      cand     <= '0;
      cnt      <= '0;
      gray_out <= '0;
      upd      <= 1'b0;
      gray_err <= 1'b0;
    end else begin
      sync_m   <= sw_in;
      sync_q   <= sync_m;
      state    <= state_d;
      cand     <= cand_d;
      cnt      <= cnt_d;
      gray_out <= gray_d;
      upd      <= upd_d;
      gray_err <= err_d;
    end
  end
  // A bounce back to the current output abandons the candidate without an update.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    gray_d  = gray_out;
    upd_d   = 1'b0;
    err_d   = gray_err;
    if (state == STABLE) begin
      if (sync_q != gray_out) begin
        state_d = SETTLE;
        cand_d  = sync_q;
        cnt_d   = '0;
      end
    end else if (sync_q != cand) begin
      state_d = (sync_q == gray_out) ? STABLE : SETTLE;
      cand_d  = (sync_q == gray_out) ? cand : sync_q;
      cnt_d   = '0;
    end else if (cnt == CNT_MAX) begin
      state_d = STABLE;
      gray_d  = cand;
      upd_d   = 1'b1;
      err_d   = $countones(cand ^ gray_out) > 1;
    end else begin
      cnt_d = cnt + 1'b1;
    end
  end
  assign busy = state == SETTLE;
endmodule

// File: tb/tb_module_gray_input.sv
// tb_module_gray_input: vector table plus hand sequences, updates checked against a scoreboard.
module tb_module_gray_input;
  logic       clk, rst_n;
  logic [3:0] sw_in, gray_out;
  logic       upd, busy, gray_err;
  int         vectors = 0, miscompares = 0, cyc = 0;
  bit         busy_seen;

  typedef struct {logic [3:0] sw; logic upd; logic [3:0] gray; logic err;} vec_t;
  typedef struct {logic [3:0] gray; logic err; int at;} exp_t;
  vec_t tbl[9];
  exp_t q[$];

  module_gray_input #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .gray_out(gray_out),
    .upd(upd), .busy(busy), .gray_err(gray_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus is driven just after a negedge, so the load edge lands 7 posedges later.
  task automatic expect_upd(input logic [3:0] g, input logic e);
    exp_t x;
    x.gray = g; x.err = e; x.at = cyc + 7;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (upd) begin
        if (q.size() == 0) chk("unexpected_upd", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("upd_cycle", cyc, e.at);
          chk("upd_gray_out", gray_out, e.gray);
          chk("upd_gray_err", gray_err, e.err);
        end
      end else if (q.size() != 0 && cyc > q[0].at) begin
        chk("late_upd", 0, 1);
        q.delete(0);
      end
      if (busy) busy_seen = 1;
    end
  end

  initial begin
    tbl[0] = '{4'b0110, 1'b1, 4'b0110, 1'b1};
    tbl[1] = '{4'b0111, 1'b1, 4'b0111, 1'b0};
    tbl[2] = '{4'b0111, 1'b0, 4'b0111, 1'b0};
    tbl[3] = '{4'b0101, 1'b1, 4'b0101, 1'b0};
    tbl[4] = '{4'b1010, 1'b1, 4'b1010, 1'b1};
    tbl[5] = '{4'b1011, 1'b1, 4'b1011, 1'b0};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[7] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    rst_n = 0;
    sw_in = 4'b0000;
    wait_n(3);
    chk("rst_gray_out", gray_out, 0);
    chk("rst_upd", upd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gray_err", gray_err, 0);
    rst_n = 1;
    wait_n(2);
    // clean step with busy profile over E0..E7
    sw_in = 4'b0001;
    expect_upd(4'b0001, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      wait_n(1);
      chk("step_busy", busy, (k >= 3 && k <= 6) ? 1 : 0);
      if (k == 8) chk("step_upd_one_cycle", upd, 0);
    end
    sw_in = 4'b0000;
    expect_upd(4'b0000, 1'b0);
    wait_n(10);
    // bounce on bit 0, then hold 1
    for (int i = 0; i < 6; i++) begin
      sw_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      wait_n(2);
    end
    sw_in = 4'b0001;
    expect_upd(4'b0001, 1'b0);
    wait_n(10);
    chk("bounce_gray_out", gray_out, 4'b0001);
    // glitch reject
    busy_seen = 0;
    sw_in = 4'b0011;
    wait_n(2);
    sw_in = 4'b0001;
    wait_n(8);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_gray_out", gray_out, 4'b0001);
    // table-driven steps
    for (int i = 0; i < 9; i++) begin
      busy_seen = 0;
      sw_in = tbl[i].sw;
      if (tbl[i].upd) expect_upd(tbl[i].gray, tbl[i].err);
      wait_n(10);
      chk("tbl_gray_out", gray_out, tbl[i].gray);
      chk("tbl_gray_err", gray_err, tbl[i].err);
      if (!tbl[i].upd) chk("tbl_nochange_busy", busy_seen, 0);
    end
    // reset in the middle of SETTLE
    sw_in = 4'b0100;
    repeat (4) @(posedge clk);
    #1 chk("mid_busy_before_rst", busy, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_gray_out", gray_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_upd", upd, 0);
    @(negedge clk);
    rst_n = 1;
    expect_upd(4'b0100, 1'b0);
    wait_n(10);
    chk("mid_post_gray_out", gray_out, 4'b0100);
    // asynchronous reset with a held multi-bit input
    sw_in = 4'b1010;
    expect_upd(4'b1010, 1'b1);
    wait_n(10);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_rst_gray_out", gray_out, 0);
    chk("async_rst_upd", upd, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_gray_err", gray_err, 0);
    @(negedge clk);
    rst_n = 1;
    expect_upd(4'b1010, 1'b1);
    wait_n(10);
    chk("post_rst_gray_out", gray_out, 4'b1010);
    chk("post_rst_gray_err", gray_err, 1);
    wait_n(2);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
